// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I core: FSM states, opcodes and
// datapath select values used by the control, extender and datapath.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alucontrol_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } alusrca_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alusrcb_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEM    = 2'b01,
        RES_ALU    = 2'b10
    } resultsrc_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from aluop and the instruction funct fields.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol,
    output logic       illegal_funct
);

    always_comb begin
        alucontrol    = ALU_ADD;
        illegal_funct = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alucontrol = ALU_AND;
                    3'b110:  alucontrol = ALU_OR;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b101:  alucontrol = ALU_SRL;
                    default: illegal_funct = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle RV32I core: drives datapath selects,
// write enables and the req/ready memory handshake; traps on unsupported ops.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [2:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t     state, next;
    logic [1:0] aluop;
    logic       illegal_funct;
    logic       req_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c, illegal_c;

    alu_decoder u_alu_decoder (
        .op5          (op[5]),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .aluop        (aluop),
        .alucontrol   (alucontrol),
        .illegal_funct(illegal_funct)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= RESET_STATE_FETCH ? S_FETCH : S_TRAP;
        else        state <= next;
    end

    always_comb begin
        next       = state;
        req_c      = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        resultsrc  = RES_ALUOUT;
        aluop      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req_c     = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                irwrite_c = mem_ready;
                pcwrite_c = mem_ready;
                if (mem_ready) next = S_DECODE;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next = S_MEMADR;
                    OP_RTYPE:          next = S_EXECR;
                    OP_ITYPE:          next = S_EXECI;
                    OP_BRANCH:         next = S_BRANCH;
                    OP_JAL:            next = S_JAL;
                    OP_LUI:            next = S_LUI;
                    default:           next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_c  = 1'b1;
                adrsrc = 1'b1;
                if (mem_ready) next = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = RES_MEM;
                regwrite_c = 1'b1;
                next       = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c      = 1'b1;
                memwrite_c = 1'b1;
                adrsrc     = 1'b1;
                if (mem_ready) next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
                aluop   = ALUOP_FUNCT;
                next    = illegal_funct ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                next       = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_SUB;
                // Only beq/bne are supported; funct3[0] inverts the taken sense.
                if (funct3[2:1] == 2'b00) begin
                    pcwrite_c = zero ^ funct3[0];
                    next      = S_FETCH;
                end else begin
                    next = S_TRAP;
                end
            end
            S_JAL: begin
                alusrca   = SRCA_OLDPC;
                alusrcb   = SRCB_FOUR;
                pcwrite_c = 1'b1;
                next      = S_ALUWB;
            end
            S_LUI: begin
                alusrca = SRCA_ZERO;
                alusrcb = SRCB_IMM;
                next    = S_ALUWB;
            end
            S_TRAP: illegal_c = 1'b1;
            default: next = S_TRAP;
        endcase
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE: immsrc = IMM_I;
            OP_STORE:          immsrc = IMM_S;
            OP_BRANCH:         immsrc = IMM_B;
            OP_JAL:            immsrc = IMM_J;
            OP_LUI:            immsrc = IMM_U;
            default:           immsrc = IMM_I;
        endcase
    end

    // Enables are masked by reset so nothing writes while reset is held low.
    assign mem_req  = req_c & reset;
    assign memwrite = memwrite_c & reset;
    assign irwrite  = irwrite_c & reset;
    assign pcwrite  = pcwrite_c & reset;
    assign regwrite = regwrite_c & reset;
    assign illegal  = illegal_c & reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push
// hand-computed per-cycle control words; a monitor compares them at negedge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, illegal;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic [2:0] immsrc, alucontrol;

    logic [6:0] i_op = 7'b0110011;
    logic [2:0] i_f3 = 3'b000;
    logic       i_f7 = 1'b0;

    typedef struct {
        logic [18:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_control #(.RESET_STATE_FETCH(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc), .immsrc(immsrc),
        .alucontrol(alucontrol), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {mem_req,memwrite,adrsrc,irwrite,pcwrite,regwrite,alusrca,alusrcb,resultsrc,immsrc,alucontrol,illegal}
    function automatic logic [18:0] ov(input logic mr, mw, as, ir, pw, rw,
                                       input logic [1:0] a, b, rs,
                                       input logic [2:0] imm, alu, input logic ill);
        return {mr, mw, as, ir, pw, rw, a, b, rs, imm, alu, ill};
    endfunction

    function automatic logic [18:0] v_fetch(input logic [2:0] imm);
        return ov(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic logic [18:0] v_decode(input logic [2:0] imm);
        return ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, 0);
    endfunction

    function automatic logic [18:0] v_aluwb(input logic [2:0] imm);
        return ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    endfunction

    task automatic cyc(input logic rst, input logic mr, input logic z,
                       input logic [18:0] e, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        op        = i_op;
        funct3    = i_f3;
        funct7b5  = i_f7;
        x.v       = e;
        x.name    = name;
        q.push_back(x);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        i_op = o;
        i_f3 = f3;
        i_f7 = f7;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [18:0] act;
            x   = q.pop_front();
            act = {mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, alusrca,
                   alusrcb, resultsrc, immsrc, alucontrol, illegal};
            checks++;
            if (act !== x.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", x.name, act, x.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held low: state is FETCH but every enable masked
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0), "reset_hold");

        // add x3,x1,x2
        cyc(1, 1, 0, v_fetch(3'b000), "add_fetch");
        cyc(1, 1, 0, v_decode(3'b000), "add_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 0), "add_execr");
        cyc(1, 1, 0, v_aluwb(3'b000), "add_aluwb");

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc(1, 1, 0, v_fetch(3'b000), "sub_fetch");
        cyc(1, 1, 0, v_decode(3'b000), "sub_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b001, 0), "sub_execr");
        cyc(1, 1, 0, v_aluwb(3'b000), "sub_aluwb");

        // lw with two wait cycles in MEMREAD: 7 cycles total
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc(1, 1, 0, v_fetch(3'b000), "lw_fetch");
        cyc(1, 1, 0, v_decode(3'b000), "lw_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0), "lw_memadr");
        cyc(1, 0, 0, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), "lw_memread_wait1");
        cyc(1, 0, 0, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), "lw_memread_wait2");
        cyc(1, 1, 0, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), "lw_memread_ready");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 0), "lw_memwb");

        // sw with one fetch wait cycle
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc(1, 0, 0, ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b001, 3'b000, 0), "sw_fetch_wait");
        cyc(1, 1, 0, v_fetch(3'b001), "sw_fetch");
        cyc(1, 1, 0, v_decode(3'b001), "sw_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 3'b000, 0), "sw_memadr");
        cyc(1, 1, 0, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0), "sw_memwrite");

        // beq taken, bne not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc(1, 1, 0, v_fetch(3'b010), "beq_fetch");
        cyc(1, 1, 0, v_decode(3'b010), "beq_decode");
        cyc(1, 1, 1, ov(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 3'b010, 3'b001, 0), "beq_branch");
        set_instr(7'b1100011, 3'b001, 1'b0);
        cyc(1, 1, 0, v_fetch(3'b010), "bne_fetch");
        cyc(1, 1, 0, v_decode(3'b010), "bne_decode");
        cyc(1, 1, 1, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b010, 3'b001, 0), "bne_branch");

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc(1, 1, 0, v_fetch(3'b011), "jal_fetch");
        cyc(1, 1, 0, v_decode(3'b011), "jal_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 0), "jal_jal");
        cyc(1, 1, 0, v_aluwb(3'b011), "jal_aluwb");

        // lui
        set_instr(7'b0110111, 3'b000, 1'b0);
        cyc(1, 1, 0, v_fetch(3'b100), "lui_fetch");
        cyc(1, 1, 0, v_decode(3'b100), "lui_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 3'b100, 3'b000, 0), "lui_lui");
        cyc(1, 1, 0, v_aluwb(3'b100), "lui_aluwb");

        // xori
        set_instr(7'b0010011, 3'b100, 1'b0);
        cyc(1, 1, 0, v_fetch(3'b000), "xori_fetch");
        cyc(1, 1, 0, v_decode(3'b000), "xori_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b100, 0), "xori_execi");
        cyc(1, 1, 0, v_aluwb(3'b000), "xori_aluwb");

        // unsupported opcode traps; sticky until reset
        set_instr(7'b0001111, 3'b000, 1'b0);
        cyc(1, 1, 0, v_fetch(3'b000), "fence_fetch");
        cyc(1, 1, 0, v_decode(3'b000), "fence_decode");
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), "trap_hold");
        cyc(0, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), "trap_reset_low");
        cyc(1, 1, 0, v_fetch(3'b000), "post_trap_fetch");

        // unsupported funct3 on ALU-imm also traps from EXECI
        set_instr(7'b0010011, 3'b011, 1'b0);
        cyc(1, 1, 0, v_decode(3'b000), "sltiu_decode");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0), "sltiu_execi");
        cyc(1, 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), "sltiu_trap");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencer for the multicycle RV32I core in miniproj4.
- A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback.
- It drives every datapath select and write enable, including the `immsrc` select consumed by the immediate extender, plus a req/ready memory handshake.
- Unsupported opcodes park the core in a sticky trap state.

Parameters:
- RESET_STATE_FETCH, 1, when 1 the FSM leaves reset in FETCH; when 0 it leaves reset in TRAP (bring-up hold).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low; state resets when sampled low at a clk edge
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag for the current cycle
- mem_ready  in  1  memory completed the current request this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  store enable, valid with mem_req
- adrsrc  out  1  0=PC, 1=ALUOut as memory address
- irwrite  out  1  load instruction register and oldPC
- pcwrite  out  1  load PC from result bus
- regwrite  out  1  register file write
- alusrca  out  2  00=PC, 01=oldPC, 10=rs1, 11=zero
- alusrcb  out  2  00=rs2, 01=immext, 10=constant 4
- resultsrc  out  2  00=ALUOut, 01=mem data, 10=ALU result
- immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- illegal  out  1  sticky unsupported-instruction flag

Behaviour:
- Reset
  - reset low at an edge: state<=FETCH (or TRAP per parameter).
  - While reset is low, mem_req, memwrite, irwrite, pcwrite, regwrite and illegal are forced 0, regardless of state.
  - Reset mid-instruction abandons it; no partial writes occur after the reset edge.
- Outputs
  - Decoded combinationally from the state register and the instruction fields.
  - Defaults: all enables 0, selects 0, alucontrol add.
  - immsrc is decoded from op in every state: loads/ALU-imm I, store S, branch B, jal J, lui U, else 000.
- States and transitions
  - FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10, add.
    - irwrite=pcwrite=mem_ready. Stay until mem_ready, then DECODE.
  - DECODE: alusrca=01, alusrcb=01, add (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - else -> TRAP
  - MEMADR: alusrca=10, alusrcb=01, add. Next: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
  - MEMREAD: mem_req=1, adrsrc=1. Stay until mem_ready, then MEMWB.
  - MEMWB: resultsrc=01, regwrite=1 -> FETCH.
  - MEMWRITE: mem_req=1, memwrite=1, adrsrc=1. Stay until mem_ready, then FETCH.
  - EXECR: alusrca=10, alusrcb=00, funct decode -> ALUWB.
  - EXECI: alusrca=10, alusrcb=01, funct decode -> ALUWB.
  - ALUWB: resultsrc=00, regwrite=1 -> FETCH.
  - BRANCH: alusrca=10, alusrcb=00, sub, resultsrc=00.
    - pcwrite = zero XOR funct3[0] (beq/bne only).
    - Other funct3 -> TRAP with pcwrite=0. Otherwise -> FETCH.
  - JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1 -> ALUWB (rd<=oldPC+4).
  - LUI: alusrca=11, alusrcb=01, add -> ALUWB.
  - TRAP: all enables 0, illegal=1. Exits only on reset.
- Funct decode
  - funct3 000 selects add, or sub when (op[5] & funct7b5).
  - 111 and, 110 or, 100 xor, 010 slt, 001 sll, 101 srl.
  - 011 -> TRAP from EXECR/EXECI.
- Timing
  - CPI with zero wait states: load 5, store 4, R/I/lui/jal 4, branch 3.
  - Each cycle mem_ready stays 0 adds one cycle.
  - mem_ready outside a mem_req state is ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - the state enum
  - opcode constants
  - immsrc, alucontrol, alusrca/b and resultsrc encodings
- The extender and the datapath must import these same encodings.
- One sub-module, alu_decoder (combinational: op[5], funct3, funct7b5, aluop -> alucontrol, illegal_funct).
- The FSM stays in multicycle_control.

Test Plan:
- Hold reset=0 for 3 cycles with mem_ready=1 -> all enables 0. Release -> first cycle FETCH with mem_req=1, irwrite=1, pcwrite=1.
- Run add x3,x1,x2 (op 0110011, f3 000, f7b5 0) with mem_ready=1 -> states FETCH,DECODE,EXECR,ALUWB. alucontrol=000 in EXECR, regwrite=1 only in ALUWB; sub variant (f7b5=1) -> 001.
- Run lw with mem_ready low for 2 cycles in MEMREAD -> stays MEMREAD with adrsrc=1, immsrc=000. MEMWB follows the mem_ready cycle; total 7 cycles.
- Run beq with zero=1 -> pcwrite=1 in BRANCH, immsrc=010. bne with zero=1 -> pcwrite=0.
- Run jal (op 1101111) -> immsrc=011, pcwrite=1 in JAL, then regwrite in ALUWB. lui -> immsrc=100, alusrca=11.
- Run op 0001111 -> TRAP, illegal=1 for 10 cycles with no enables. reset low one edge -> FETCH, illegal=0.
